// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: forwarding-select
// encodings, FSM state encoding and the default register-address width.
package hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  // Operand source selects for the E-stage ALU inputs
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // RUN: normal flow; MWAIT: whole pipe frozen on an outstanding data access
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forward-select logic for one E-stage ALU operand. The M stage holds the
// younger result, so it wins over W when both match the source register.
// Register x0 never forwards. i_en low forces the register-file select.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int AW = hazard_ctrl_pkg::REG_AW
) (
  input  logic          i_en,
  input  logic [AW-1:0] i_rsE,
  input  logic [AW-1:0] i_rdM,
  input  logic          i_regWriteM,
  input  logic [AW-1:0] i_rdW,
  input  logic          i_regWriteW,
  output logic [1:0]    o_sel
);

  // Pick the newest in-flight producer of the source register
  always_comb begin
    o_sel = FWD_RF;
    if (i_en) begin
      if (i_regWriteM && (i_rdM != '0) && (i_rdM == i_rsE)) begin
        o_sel = FWD_M;
      end else if (i_regWriteW && (i_rdW != '0) && (i_rdW == i_rsE)) begin
        o_sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: operand forwarding,
// load-use stalls, branch flushes, memory-wait freezes and deferred flushes.
// Optional saturating hazard counters are built when HAZ_PERF_CNT_EN is
// defined; otherwise the counter outputs are tied to zero.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = hazard_ctrl_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ResultSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  ld_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  mwait_cnt
);

  state_t r_state;
  state_t w_nextState;
  logic   r_flushPend;
  logic   w_flushPendNext;
  logic   w_lwStall;
  logic   w_memWait;
  logic   w_frozen;
  logic   w_stallF, w_stallD, w_stallE, w_stallM;
  logic   w_flushD, w_flushE;

  assign w_lwStall = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_memWait = MemReqM && !MemReadyM;

  hazard_fwd_unit #(.AW(REG_AW)) u_fwdA (
    .i_en        (rst),
    .i_rsE       (Rs1E),
    .i_rdM       (RdM),
    .i_regWriteM (RegWriteM),
    .i_rdW       (RdW),
    .i_regWriteW (RegWriteW),
    .o_sel       (ForwardAE)
  );

  hazard_fwd_unit #(.AW(REG_AW)) u_fwdB (
    .i_en        (rst),
    .i_rsE       (Rs2E),
    .i_rdM       (RdM),
    .i_regWriteM (RegWriteM),
    .i_rdW       (RdW),
    .i_regWriteW (RegWriteW),
    .o_sel       (ForwardBE)
  );

  // State register and pending-flush flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_flushPend <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_flushPend <= w_flushPendNext;
    end
  end

  // Next state, stall/flush decode; a taken branch seen while frozen is parked
  always_comb begin
    w_nextState     = r_state;
    w_frozen        = 1'b0;
    w_stallF        = 1'b0;
    w_stallD        = 1'b0;
    w_stallE        = 1'b0;
    w_stallM        = 1'b0;
    w_flushD        = 1'b0;
    w_flushE        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_memWait) begin
          w_frozen    = 1'b1;
          w_nextState = ST_MWAIT;
        end else begin
          w_stallF = w_lwStall;
          w_stallD = w_lwStall;
          w_flushE = w_lwStall || PCSrcE || r_flushPend;
          w_flushD = PCSrcE || r_flushPend;
        end
      end
      ST_MWAIT: begin
        w_frozen = 1'b1;
        if (MemReadyM) begin
          w_nextState = ST_RUN;
        end
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
    if (w_frozen) begin
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_stallE = 1'b1;
      w_stallM = 1'b1;
    end
    w_flushPendNext = w_frozen ? (r_flushPend || PCSrcE) : 1'b0;
  end

  // Control outputs are held inactive while reset is asserted
  always_comb begin
    StallF = rst && w_stallF;
    StallD = rst && w_stallD;
    StallE = rst && w_stallE;
    StallM = rst && w_stallM;
    FlushD = rst && w_flushD;
    FlushE = rst && w_flushE;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_ldStallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic [CNT_W-1:0] r_mwaitCnt;
  logic             w_ldStallEvt;

  assign w_ldStallEvt = (r_state == ST_RUN) && w_lwStall && !w_memWait;

  // Saturating hazard event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ldStallCnt <= '0;
      r_flushCnt   <= '0;
      r_mwaitCnt   <= '0;
    end else begin
      if (w_ldStallEvt && (r_ldStallCnt != '1)) begin
        r_ldStallCnt <= r_ldStallCnt + CNT_W'(1);
      end
      if (w_flushD && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
      if (w_frozen && (r_mwaitCnt != '1)) begin
        r_mwaitCnt <= r_mwaitCnt + CNT_W'(1);
      end
    end
  end

  assign ld_stall_cnt = r_ldStallCnt;
  assign flush_cnt    = r_flushCnt;
  assign mwait_cnt    = r_mwaitCnt;
`else
  assign ld_stall_cnt = '0;
  assign flush_cnt    = '0;
  assign mwait_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled 2 units later, well before the next edge.
// Counter expectations depend on whether HAZ_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] ld_stall_cnt, flush_cnt, mwait_cnt;
  logic [5:0]  ctrl;

  int checkCount = 0;
  int failCount  = 0;

  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .ResultSrcE   (ResultSrcE),
    .RdM          (RdM),
    .RegWriteM    (RegWriteM),
    .RdW          (RdW),
    .RegWriteW    (RegWriteW),
    .PCSrcE       (PCSrcE),
    .MemReqM      (MemReqM),
    .MemReadyM    (MemReadyM),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .ld_stall_cnt (ld_stall_cnt),
    .flush_cnt    (flush_cnt),
    .mwait_cnt    (mwait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expCnt(input int n);
`ifdef HAZ_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // Advance to just after the next rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    // Reset: even with matching forward sources and a memory wait, all quiet
    RdM = 5; RegWriteM = 1; Rs1E = 5; MemReqM = 1; PCSrcE = 1;
    #3;
    checkOutput("rst_ctrl", 32'(ctrl), 32'b000000);
    checkOutput("rst_fwdA", 32'(ForwardAE), 32'b00);
    checkOutput("rst_cnt", 32'(mwait_cnt), 32'd0);
    clearInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Forwarding
    applyStimulus();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    #2;
    checkOutput("fwdA_M", 32'(ForwardAE), 32'b10);
    checkOutput("fwdB_rs0", 32'(ForwardBE), 32'b00);
    checkOutput("fwd_ctrl", 32'(ctrl), 32'b000000);
    RdM = 0; Rs2E = 5;
    #1;
    checkOutput("fwdA_W", 32'(ForwardAE), 32'b01);
    checkOutput("fwdB_W", 32'(ForwardBE), 32'b01);
    RdW = 0;
    #1;
    checkOutput("fwdB_rd0", 32'(ForwardBE), 32'b00);
    RdW = 5; RegWriteW = 0; RdM = 5; RegWriteM = 0;
    #1;
    checkOutput("fwdA_nowr", 32'(ForwardAE), 32'b00);
    clearInputs();

    // Load-use stall
    applyStimulus();
    ResultSrcE = 1; RdE = 7; Rs2D = 7;
    #2;
    checkOutput("lw_ctrl", 32'(ctrl), 32'b110001);
    RdE = 0; Rs2D = 0;
    #1;
    checkOutput("lw_rd0", 32'(ctrl), 32'b000000);
    RdE = 7; Rs2D = 7;
    applyStimulus();
    clearInputs();
    #2;
    checkOutput("lw_after", 32'(ctrl), 32'b000000);
    checkOutput("lw_cnt", 32'(ld_stall_cnt), expCnt(1));

    // Branch flush
    applyStimulus();
    PCSrcE = 1;
    #2;
    checkOutput("br_ctrl", 32'(ctrl), 32'b000011);
    applyStimulus();
    PCSrcE = 0;
    #2;
    checkOutput("br_after", 32'(ctrl), 32'b000000);
    checkOutput("br_cnt", 32'(flush_cnt), expCnt(1));

    // Memory wait: three not-ready cycles then ready
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      MemReqM = 1; MemReadyM = 0;
      #2;
      checkOutput($sformatf("mw_frz%0d", i), 32'(ctrl), 32'b111100);
    end
    applyStimulus();
    MemReadyM = 1;
    #2;
    checkOutput("mw_last", 32'(ctrl), 32'b111100);
    applyStimulus();
    clearInputs();
    #2;
    checkOutput("mw_run", 32'(ctrl), 32'b000000);
    checkOutput("mw_cnt", 32'(mwait_cnt), expCnt(4));

    // Branch resolved while frozen: deferred flush fires once
    applyStimulus();
    MemReqM = 1; MemReadyM = 0;
    #2;
    checkOutput("df_frz0", 32'(ctrl), 32'b111100);
    applyStimulus();
    PCSrcE = 1;
    #2;
    checkOutput("df_frz1", 32'(ctrl), 32'b111100);
    applyStimulus();
    MemReadyM = 1;
    #2;
    checkOutput("df_frz2", 32'(ctrl), 32'b111100);
    applyStimulus();
    MemReqM = 0; MemReadyM = 0;
    #2;
    checkOutput("df_fire", 32'(ctrl), 32'b000011);
    applyStimulus();
    PCSrcE = 0;
    #2;
    checkOutput("df_once", 32'(ctrl), 32'b000000);
    checkOutput("df_fcnt", 32'(flush_cnt), expCnt(2));
    checkOutput("df_mcnt", 32'(mwait_cnt), expCnt(7));

    // Load-use together with a taken branch
    applyStimulus();
    ResultSrcE = 1; RdE = 9; Rs1D = 9; PCSrcE = 1;
    #2;
    checkOutput("lwbr_ctrl", 32'(ctrl), 32'b110011);

    // Memory wait overrides load-use and branch
    applyStimulus();
    MemReqM = 1; MemReadyM = 0;
    #2;
    checkOutput("ovr_frz0", 32'(ctrl), 32'b111100);
    applyStimulus();
    MemReadyM = 1;
    #2;
    checkOutput("ovr_frz1", 32'(ctrl), 32'b111100);
    applyStimulus();
    MemReqM = 0; MemReadyM = 0;
    #2;
    checkOutput("ovr_run", 32'(ctrl), 32'b110011);
    applyStimulus();
    clearInputs();
    #2;
    checkOutput("ovr_idle", 32'(ctrl), 32'b000000);
    checkOutput("ovr_lcnt", 32'(ld_stall_cnt), expCnt(3));
    checkOutput("ovr_fcnt", 32'(flush_cnt), expCnt(4));
    checkOutput("ovr_mcnt", 32'(mwait_cnt), expCnt(9));

    // Reset during MWAIT with a pending flush
    applyStimulus();
    MemReqM = 1; MemReadyM = 0;
    applyStimulus();
    PCSrcE = 1;
    applyStimulus();
    PCSrcE = 0;
    RdM = 3; RegWriteM = 1; Rs2E = 3;
    rst = 1'b0;
    #1;
    checkOutput("mrst_ctrl", 32'(ctrl), 32'b000000);
    checkOutput("mrst_fwdB", 32'(ForwardBE), 32'b00);
    checkOutput("mrst_cnt", 32'(mwait_cnt), 32'd0);
    clearInputs();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    #2;
    checkOutput("mrst_noflush", 32'(ctrl), 32'b000000);
    MemReqM = 1; MemReadyM = 1;
    #1;
    checkOutput("mrst_run", 32'(ctrl), 32'b000000);
    clearInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
